// File: rtl/layer3_pkg.sv
// Shared constants and FSM state type for the layer-3 bottleneck weight path.
// Both the streamer and its benches use these default segment sizes.
package layer3_pkg;

    localparam int L3_DATA_WIDTH = 32;
    localparam int L3_CNT_WIDTH  = 20;

    localparam int L3_COUNT1 = 131072;  // conv1 1x1 512->256
    localparam int L3_COUNT2 = 589824;  // conv2 3x3 256->256
    localparam int L3_COUNT3 = 262144;  // conv3 1x1 256->1024
    localparam int L3_COUNT4 = 524288;  // conv4 proj 1x1 512->1024

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEG1,
        S_SEG2,
        S_SEG3,
        S_SEG4,
        S_DONE
    } l3_state_e;

endpackage

// File: rtl/layer3_weight_streamer_if.sv
// Upstream weight-word valid/ready channel feeding the layer-3 streamer.
interface layer3_weight_streamer_if #(
    parameter int DATA_WIDTH = layer3_pkg::L3_DATA_WIDTH
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/weight_seg_counter.sv
// Up-counter with clear/enable and a terminal-count flag against a runtime limit.
module weight_seg_counter #(
    parameter int CNT_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    // tc marks the position whose accept completes the segment
    assign tc    = (cnt_q == limit - 1'b1);

endmodule

// File: rtl/layer3_weight_streamer.sv
// Routes one upstream weight stream into the four layer-3 conv weight ports in segment order.
// Optional per-segment checksum is built only when WEIGHT_CHECKSUM_EN is defined.
module layer3_weight_streamer
    import layer3_pkg::*;
#(
    parameter int DATA_WIDTH = L3_DATA_WIDTH,
    parameter int CNT_WIDTH  = L3_CNT_WIDTH,
    parameter int COUNT1     = L3_COUNT1,
    parameter int COUNT2     = L3_COUNT2,
    parameter int COUNT3     = L3_COUNT3,
    parameter int COUNT4     = L3_COUNT4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    layer3_weight_streamer_if.slave         up,
    output logic                            valid_weight_out1,
    output logic                            valid_weight_out2,
    output logic                            valid_weight_out3,
    output logic                            valid_weight_out4,
    output logic [DATA_WIDTH-1:0]           weight_out1,
    output logic [DATA_WIDTH-1:0]           weight_out2,
    output logic [DATA_WIDTH-1:0]           weight_out3,
    output logic [DATA_WIDTH-1:0]           weight_out4,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH-1:0]           checksum
);

    if (COUNT1 <= 0 || COUNT2 <= 0 || COUNT3 <= 0 || COUNT4 <= 0) begin : g_bad_count
        $error("layer3_weight_streamer: every COUNTn must be non-zero");
    end
    if (longint'(COUNT1) >= (longint'(1) << CNT_WIDTH) || longint'(COUNT2) >= (longint'(1) << CNT_WIDTH) ||
        longint'(COUNT3) >= (longint'(1) << CNT_WIDTH) || longint'(COUNT4) >= (longint'(1) << CNT_WIDTH))
    begin : g_bad_width
        $error("layer3_weight_streamer: CNT_WIDTH too small for COUNTn");
    end

    l3_state_e state_q, state_d;
    logic [3:0]                 vld_q, vld_d;
    logic [3:0][DATA_WIDTH-1:0] wt_q, wt_d;
    logic                       done_q, done_d;

    logic                 in_seg, accept, start_go, seg_last;
    logic [1:0]           seg_idx;
    logic [CNT_WIDTH-1:0] limit, cnt;
    logic                 cnt_tc;

    assign in_seg   = (state_q == S_SEG1) || (state_q == S_SEG2) ||
                      (state_q == S_SEG3) || (state_q == S_SEG4);
    assign accept   = up.in_valid && in_seg;
    assign seg_last = accept && cnt_tc;

    always_comb begin
        seg_idx = 2'd0;
        limit   = CNT_WIDTH'(COUNT1);
        unique case (state_q)
            S_SEG2:  begin seg_idx = 2'd1; limit = CNT_WIDTH'(COUNT2); end
            S_SEG3:  begin seg_idx = 2'd2; limit = CNT_WIDTH'(COUNT3); end
            S_SEG4:  begin seg_idx = 2'd3; limit = CNT_WIDTH'(COUNT4); end
            default: begin seg_idx = 2'd0; limit = CNT_WIDTH'(COUNT1); end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin state_d = S_SEG1; start_go = 1'b1; end
            S_SEG1: if (seg_last) state_d = S_SEG2;
            S_SEG2: if (seg_last) state_d = S_SEG3;
            S_SEG3: if (seg_last) state_d = S_SEG4;
            S_SEG4: if (seg_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            start_go = 1'b0;
        end
    end

    // An accept in the abort cycle is still emitted downstream
    always_comb begin
        vld_d  = '0;
        wt_d   = wt_q;
        done_d = (state_q == S_DONE) && !abort;
        if (accept) begin
            vld_d[seg_idx] = 1'b1;
            wt_d[seg_idx]  = up.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            wt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            wt_q    <= wt_d;
            done_q  <= done_d;
        end
    end

    weight_seg_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_go || abort || seg_last),
        .en    (accept),
        .limit (limit),
        .count (cnt),
        .tc    (cnt_tc)
    );

`ifdef WEIGHT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] cks_q, cks_d;
    logic                  seg_end_q, seg_end_d;

    // The completed sum is shown for one cycle, then the next segment starts from zero
    always_comb begin
        cks_d     = seg_end_q ? '0 : cks_q;
        if (accept)
            cks_d = cks_d + up.in_data;
        if (abort || start_go)
            cks_d = '0;
        seg_end_d = seg_last && !abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cks_q     <= '0;
            seg_end_q <= 1'b0;
        end else begin
            cks_q     <= cks_d;
            seg_end_q <= seg_end_d;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    assign up.in_ready       = in_seg;
    assign busy              = in_seg;
    assign done              = done_q;
    assign valid_weight_out1 = vld_q[0];
    assign valid_weight_out2 = vld_q[1];
    assign valid_weight_out3 = vld_q[2];
    assign valid_weight_out4 = vld_q[3];
    assign weight_out1       = wt_q[0];
    assign weight_out2       = wt_q[1];
    assign weight_out3       = wt_q[2];
    assign weight_out4       = wt_q[3];

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: doc/layer3_weight_streamer.md
# layer3_weight_streamer

Splits one upstream weight word stream into the four per-convolution weight ports of the layer-3 bottleneck (conv1 1x1 512→256, conv2 3x3 256→256, conv3 1x1 256→1024, conv4 projection 1x1 512→1024). The block is the transmit side of the `valid_weight_in*` / `weight_in*` interface. It takes words from a memory/DMA source over a valid/ready handshake and routes them in a fixed segment order. Each routed word is emitted as a registered single-cycle valid pulse on the selected port. It sits between the weight loader and the bottleneck block.

## Interface
- DATA_WIDTH, 32, weight word width (IEEE-754 single)
- CNT_WIDTH, 20, segment counter width; must satisfy 2^CNT_WIDTH > max COUNTn
- COUNT1, 131072, words for conv1 (512·256·1·1)
- COUNT2, 589824, words for conv2 (256·256·3·3)
- COUNT3, 262144, words for conv3 (256·1024·1·1)
- COUNT4, 524288, words for conv4 (512·1024·1·1)

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load when idle
- abort  in  1  synchronous; terminates a load
- in_valid  in  1  upstream word valid
- in_data  in  DATA_WIDTH  upstream weight word
- in_ready  out  1  block accepts the word this cycle
- valid_weight_out1..4  out  1 each  word valid for conv1..conv4
- weight_out1..4  out  DATA_WIDTH each  weight word for conv1..conv4
- busy  out  1  high in any SEG state
- done  out  1  one-cycle pulse at the end of a complete load
- checksum  out  DATA_WIDTH  running sum of the current segment (see Configuration)

## Operation
- FSM states: IDLE, SEG1, SEG2, SEG3, SEG4, DONE.
- IDLE:
  - start=1 → SEG1; the counter clears.
  - start while busy is ignored.
- SEGn:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - On accept, in_data is registered into weight_outn and valid_weight_outn=1 for exactly the next cycle. The counter increments.
  - The accept that makes counter == COUNTn-1 moves the FSM to SEG(n+1) (SEG4 → DONE) and clears the counter.
  - No words are dropped or duplicated at segment boundaries.
- DONE:
  - done=1 for one cycle, in_ready=0, then IDLE.
  - A start during DONE is ignored.
- Only one valid_weight_out is ever high in a given cycle. The other ports' valids stay 0.
- weight_outN holds its last value when its valid is 0.
- abort=1 in any state → IDLE next cycle:
  - counter cleared, in_ready=0 from the next cycle, no done pulse.
  - A word accepted in the abort cycle is still emitted.
  - abort has priority over start in the same cycle.
- in_valid=0 in SEGn: the FSM stalls, no output pulse, counter holds. The downstream conv ports have no backpressure, so stalls only create gaps.
- COUNTn=0 is illegal (elaboration assertion).

## Timing
- Reset values:
  - state IDLE, counter 0, in_ready 0, busy 0, done 0.
  - All valid_weight_out 0, all weight_out 0, checksum 0.
- Latency: accept at cycle t → valid_weight_outn and weight_outn at t+1.
- in_ready rises the cycle after start is sampled and falls the cycle after the final SEG4 accept.
- done rises 2 cycles after the final SEG4 accept (one DONE cycle after the state change).
- Throughput: one word per cycle; a full default load is 1,507,328 accepted words minimum.
- Reset mid-load overrides everything; the next cycle matches the reset state.

## Configuration
- WEIGHT_CHECKSUM_EN defined:
  - checksum accumulates the modulo-2^DATA_WIDTH integer sum of the raw bits of each accepted word.
  - It clears on start, on each segment transition and on abort.
  - At a segment's final accept it presents that segment's complete sum and holds it for one cycle.
- WEIGHT_CHECKSUM_EN undefined: the checksum port is driven constant 0 and no adder is built.

## Structure
- Shared package `layer3_pkg`:
  - FSM state typedef (IDLE/SEG1..SEG4/DONE).
  - Default COUNT1..4 constants, so the bottleneck and its testbench use the same numbers.
- One natural sub-module: `weight_seg_counter`, a CNT_WIDTH up-counter with clear, enable and a terminal-count flag against a runtime limit. It is instantiated once and muxed by state.

## Test plan
- COUNT=4,3,2,5; start, in_valid held 1, data 1..14 → port1 gets 1–4, port2 5–7, port3 8–9, port4 10–14, each one cycle after accept; done at cycle 16 after start; in_ready 1 for exactly 14 cycles.
- Same counts, in_valid toggled 1/0 → same routing; output gaps match input gaps; counter holds during stalls.
- Abort after word 6 (in SEG2) → IDLE next cycle; word 6 is still emitted on port2; no done; a new start restarts at port1 with word 1.
- start during SEG3 and during DONE → ignored; routing unchanged; exactly one done.
- reset asserted at word 9 → all outputs at reset values the next cycle; busy 0; in_ready 0.
- WEIGHT_CHECKSUM_EN, data 1..14 → checksum presents 10, 18, 17, 60 at the final accept of each segment.
